// File: rtl/reorder_tag_if.sv
// reorder_tag_if: bundles the ingress, filter and circular_buffer facing
// signals of reorder_tag_manager.
//
// Handshake: alloc_req/alloc_gnt is a valid/ready pair. A tag transfers on a
// rising edge where both are high. alloc_gnt may rise without alloc_req
// deasserting, and alloc_tag is only meaningful while alloc_gnt is high.
// verdict_valid and release_valid are single-cycle strobes with no
// back-pressure. An illegal strobe is dropped and raises the sticky error.
interface reorder_tag_if #(
  parameter int TAG_WIDTH = 6
);
  logic                 alloc_req;
  logic                 alloc_gnt;
  logic [TAG_WIDTH-1:0] alloc_tag;
  logic                 verdict_valid;
  logic [TAG_WIDTH-1:0] verdict_tag;
  logic                 verdict_accept;
  logic                 release_valid;
  logic [TAG_WIDTH-1:0] release_tag;
  logic [TAG_WIDTH-1:0] reorder_tag_out;
  logic [1:0]           packet_status;
  logic [TAG_WIDTH:0]   free_count;
  logic                 full;
  logic                 empty;
  logic                 error;

  modport master (
    output alloc_req, verdict_valid, verdict_tag, verdict_accept,
           release_valid, release_tag, reorder_tag_out,
    input  alloc_gnt, alloc_tag, packet_status, free_count, full, empty, error
  );

  modport slave (
    input  alloc_req, verdict_valid, verdict_tag, verdict_accept,
           release_valid, release_tag, reorder_tag_out,
    output alloc_gnt, alloc_tag, packet_status, free_count, full, empty, error
  );
endinterface

// File: rtl/reorder_tag_manager.sv
// reorder_tag_manager: hands out reorder tags in circular order, records the
// filter verdict for each tag, and answers packet_status lookups for
// circular_buffer. Tags are released strictly in allocation order.
// Optional macro TAG_TIMEOUT_EN: auto-reject a tail slot that stays PENDING
// for TIMEOUT_CYCLES cycles.
module reorder_tag_manager #(
  parameter int TAG_WIDTH            = 6,
  parameter int CIRCULAR_BUFFER_SIZE = 50,
  parameter int TIMEOUT_CYCLES       = 1024
) (
  input logic          clk,
  input logic          rst,
  reorder_tag_if.slave bus
);
  localparam int                   SIZE     = CIRCULAR_BUFFER_SIZE;
  localparam logic [TAG_WIDTH-1:0] LAST_TAG = TAG_WIDTH'(SIZE - 1);
  localparam logic [TAG_WIDTH:0]   SIZE_W   = (TAG_WIDTH + 1)'(SIZE);
  localparam logic [1:0] ST_PENDING  = 2'b00;
  localparam logic [1:0] ST_REJECTED = 2'b01;
  localparam logic [1:0] ST_ACCEPTED = 2'b11;

  logic [TAG_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic [TAG_WIDTH:0]   free_q, free_d;
  logic                 full_q, full_d, empty_q, empty_d, error_q, error_d;
  logic                 alloc_q  [SIZE];
  logic                 alloc_d  [SIZE];
  logic [1:0]           status_q [SIZE];
  logic [1:0]           status_d [SIZE];

  logic                 grant;
  logic                 verdict_in_range, verdict_ok, verdict_bad;
  logic                 release_ok, release_bad;
  logic                 lookup_in_range;
  logic [TAG_WIDTH-1:0] vidx, lidx;
  logic                 timeout_fire;

  function automatic logic [TAG_WIDTH-1:0] next_ptr(input logic [TAG_WIDTH-1:0] p);
    return (p == LAST_TAG) ? '0 : p + 1'b1;
  endfunction

  // Legality of this cycle's alloc, verdict and release, all against pre-edge state.
  always_comb begin
    grant            = bus.alloc_req & ~full_q;
    verdict_in_range = ({1'b0, bus.verdict_tag} < SIZE_W);
    vidx             = verdict_in_range ? bus.verdict_tag : '0;
    verdict_ok       = bus.verdict_valid & verdict_in_range & alloc_q[vidx] &
                       (status_q[vidx] == ST_PENDING);
    verdict_bad      = bus.verdict_valid & ~verdict_ok;
    release_ok       = bus.release_valid & (bus.release_tag == tail_q) &
                       alloc_q[tail_q] & (status_q[tail_q] != ST_PENDING);
    release_bad      = bus.release_valid & ~release_ok;
  end

`ifdef TAG_TIMEOUT_EN
  localparam int             CW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] to_cnt_q, to_cnt_d;
  logic          tail_pending, tail_resolving;

  // Age of the PENDING tail slot; fires on the edge that would reach the limit.
  always_comb begin
    tail_pending   = alloc_q[tail_q] & (status_q[tail_q] == ST_PENDING);
    tail_resolving = verdict_ok & (vidx == tail_q);
    timeout_fire   = 1'b0;
    to_cnt_d       = '0;
    if (tail_pending && !empty_q && !tail_resolving) begin
      if (to_cnt_q == CNT_LAST) timeout_fire = 1'b1;
      else                      to_cnt_d     = to_cnt_q + 1'b1;
    end
  end

  // Timeout counter register.
  always_ff @(posedge clk) begin
    if (!rst) to_cnt_q <= '0;
    else      to_cnt_q <= to_cnt_d;
  end
`else
  // No counter: PENDING slots wait forever; TIMEOUT_CYCLES only kept for parity.
  assign timeout_fire = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

  // Next pointers, occupancy and flags.
  always_comb begin
    head_d = grant      ? next_ptr(head_q) : head_q;
    tail_d = release_ok ? next_ptr(tail_q) : tail_q;
    free_d = free_q;
    case ({grant, release_ok})
      2'b10:   free_d = free_q - 1'b1;
      2'b01:   free_d = free_q + 1'b1;
      default: free_d = free_q;
    endcase
    full_d  = (free_d == '0);
    empty_d = (free_d == SIZE_W);
    error_d = error_q | verdict_bad | release_bad;
  end

  // Next slot table: release frees tail, grant claims head, verdict/timeout resolve.
  always_comb begin
    for (int i = 0; i < SIZE; i++) begin
      alloc_d[i]  = alloc_q[i];
      status_d[i] = status_q[i];
    end
    if (release_ok) begin
      alloc_d[tail_q]  = 1'b0;
      status_d[tail_q] = ST_PENDING;
    end
    if (grant) begin
      alloc_d[head_q]  = 1'b1;
      status_d[head_q] = ST_PENDING;
    end
    if (verdict_ok)
      status_d[vidx] = bus.verdict_accept ? ST_ACCEPTED : ST_REJECTED;
    if (timeout_fire && !(verdict_ok && (vidx == tail_q)))
      status_d[tail_q] = ST_REJECTED;
  end

  // State registers; reset discards every slot in one cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      free_q  <= SIZE_W;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      error_q <= 1'b0;
      for (int i = 0; i < SIZE; i++) begin
        alloc_q[i]  <= 1'b0;
        status_q[i] <= ST_PENDING;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      free_q  <= free_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      error_q <= error_d;
      for (int i = 0; i < SIZE; i++) begin
        alloc_q[i]  <= alloc_d[i];
        status_q[i] <= status_d[i];
      end
    end
  end

  // Outputs: grant and lookup are combinational, flags come straight from registers.
  always_comb begin
    lookup_in_range   = ({1'b0, bus.reorder_tag_out} < SIZE_W);
    lidx              = lookup_in_range ? bus.reorder_tag_out : '0;
    bus.packet_status = (lookup_in_range && alloc_q[lidx]) ? status_q[lidx] : ST_PENDING;
    bus.alloc_gnt     = grant;
    bus.alloc_tag     = head_q;
    bus.free_count    = free_q;
    bus.full          = full_q;
    bus.empty         = empty_q;
    bus.error         = error_q;
  end
endmodule

// File: tb/tb_reorder_tag_manager.sv
// tb_reorder_tag_manager: directed sequence for a 3-slot reorder_tag_manager
// with a grant-tag scoreboard.
module tb_reorder_tag_manager;
  localparam int TW   = 2;
  localparam int SIZE = 3;
  localparam int TMO  = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  reorder_tag_if #(.TAG_WIDTH(TW)) bus ();

  reorder_tag_manager #(
    .TAG_WIDTH(TW),
    .CIRCULAR_BUFFER_SIZE(SIZE),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  logic [TW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.alloc_req       = 1'b0;
    bus.verdict_valid   = 1'b0;
    bus.verdict_tag     = '0;
    bus.verdict_accept  = 1'b0;
    bus.release_valid   = 1'b0;
    bus.release_tag     = '0;
    bus.reorder_tag_out = '0;
  endtask

  task automatic look(input string name, input logic [TW-1:0] tag, input logic [1:0] exp);
    bus.reorder_tag_out = tag;
    #1;
    chk(name, 8'(bus.packet_status), 8'(exp));
  endtask

  task automatic verdict(input logic [TW-1:0] tag, input logic acc);
    bus.verdict_valid  = 1'b1;
    bus.verdict_tag    = tag;
    bus.verdict_accept = acc;
    tick();
    bus.verdict_valid  = 1'b0;
  endtask

  task automatic release_tag(input logic [TW-1:0] tag);
    bus.release_valid = 1'b1;
    bus.release_tag   = tag;
    tick();
    bus.release_valid = 1'b0;
  endtask

  // scoreboard: every grant must match the next expected tag
  always @(negedge clk) begin
    logic [TW-1:0] e;
    if (rst && bus.alloc_gnt) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_grant", 8'(bus.alloc_tag), 8'hff);
      end else begin
        e = exp_q.pop_front();
        chk("grant_tag", 8'(bus.alloc_tag), 8'(e));
      end
    end
  end

  // watchdog
  initial begin
    #100000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] tbl [4];
    tbl[0] = 2'b01; tbl[1] = 2'b11; tbl[2] = 2'b00; tbl[3] = 2'b00;
    clear_inputs();

    // reset
    rst = 1'b0;
    tick();
    tick();
    chk("rst_free",   8'(bus.free_count), 8'd3);
    chk("rst_full",   8'(bus.full),       8'd0);
    chk("rst_empty",  8'(bus.empty),      8'd1);
    chk("rst_error",  8'(bus.error),      8'd0);
    chk("rst_tag",    8'(bus.alloc_tag),  8'd0);
    look("rst_status", 2'd0, 2'b00);
    rst = 1'b1;

    // four consecutive requests: tags 0,1,2 then refused
    for (int i = 0; i < 4; i++) begin
      bus.alloc_req = 1'b1;
      if (i < 3) exp_q.push_back(TW'(i));
      #2;
      chk("fill_gnt", 8'(bus.alloc_gnt), (i < 3) ? 8'd1 : 8'd0);
      tick();
    end
    bus.alloc_req = 1'b0;
    chk("fill_free",  8'(bus.free_count), 8'd0);
    chk("fill_full",  8'(bus.full),       8'd1);
    chk("fill_empty", 8'(bus.empty),      8'd0);

    // verdicts, then lookup every tag including out-of-range 3
    verdict(2'd1, 1'b1);
    verdict(2'd0, 1'b0);
    for (int t = 0; t < 4; t++) look("lookup", TW'(t), tbl[t]);
    chk("verdict_error", 8'(bus.error), 8'd0);

    // full: release + request in the same cycle -> no grant, grant next cycle
    bus.release_valid = 1'b1;
    bus.release_tag   = 2'd0;
    bus.alloc_req     = 1'b1;
    #2;
    chk("full_rel_gnt", 8'(bus.alloc_gnt), 8'd0);
    tick();
    bus.release_valid = 1'b0;
    chk("after_rel_free", 8'(bus.free_count), 8'd1);
    chk("after_rel_full", 8'(bus.full),       8'd0);
    exp_q.push_back(2'd0);
    #2;
    chk("wrap_gnt", 8'(bus.alloc_gnt), 8'd1);
    chk("wrap_tag", 8'(bus.alloc_tag), 8'd0);
    tick();
    bus.alloc_req = 1'b0;
    chk("wrap_free", 8'(bus.free_count), 8'd0);
    look("realloc_pending", 2'd0, 2'b00);
    chk("wrap_error", 8'(bus.error), 8'd0);

    // out-of-order release (tail is 1) -> error, nothing changes
    release_tag(2'd2);
    chk("bad_rel_error", 8'(bus.error),      8'd1);
    chk("bad_rel_free",  8'(bus.free_count), 8'd0);
    look("bad_rel_tag1", 2'd1, 2'b11);
    look("bad_rel_tag2", 2'd2, 2'b00);

    // legal release of tag1, then verdicts to a free slot and out of range
    release_tag(2'd1);
    chk("rel1_free", 8'(bus.free_count), 8'd1);
    verdict(2'd1, 1'b1);
    look("free_verdict_tag1", 2'd1, 2'b00);
    chk("free_verdict_free",  8'(bus.free_count), 8'd1);
    chk("free_verdict_error", 8'(bus.error),      8'd1);
    verdict(2'd3, 1'b1);
    chk("oor_verdict_error", 8'(bus.error), 8'd1);

    // tail slot 2 left PENDING well beyond the timeout
    repeat (12) tick();
`ifdef TAG_TIMEOUT_EN
    look("timeout_tag2", 2'd2, 2'b01);
`else
    look("timeout_tag2", 2'd2, 2'b00);
`endif

    // second verdict to a resolved slot must not overwrite it
    verdict(2'd2, 1'b0);
    verdict(2'd2, 1'b1);
    look("resolved_tag2", 2'd2, 2'b01);

    // next grant continues at head=1
    bus.alloc_req = 1'b1;
    exp_q.push_back(2'd1);
    #2;
    chk("head1_gnt", 8'(bus.alloc_gnt), 8'd1);
    tick();
    bus.alloc_req = 1'b0;
    chk("head1_free", 8'(bus.free_count), 8'd0);

    // two allocated (0 pending -> accepted, 1 pending), then reset
    release_tag(2'd2);
    chk("rel2_free", 8'(bus.free_count), 8'd1);
    verdict(2'd0, 1'b1);
    look("pre_rst_tag0", 2'd0, 2'b11);
    rst = 1'b0;
    bus.verdict_valid = 1'b1;
    bus.verdict_tag   = 2'd3;
    tick();
    bus.verdict_valid = 1'b0;
    rst = 1'b1;
    chk("mid_rst_free",  8'(bus.free_count), 8'd3);
    chk("mid_rst_full",  8'(bus.full),       8'd0);
    chk("mid_rst_empty", 8'(bus.empty),      8'd1);
    chk("mid_rst_error", 8'(bus.error),      8'd0);
    chk("mid_rst_tag",   8'(bus.alloc_tag),  8'd0);
    look("mid_rst_tag0", 2'd0, 2'b00);

    // first grant after reset is tag 0
    bus.alloc_req = 1'b1;
    exp_q.push_back(2'd0);
    #2;
    chk("post_rst_gnt", 8'(bus.alloc_gnt), 8'd1);
    tick();
    bus.alloc_req = 1'b0;
    chk("post_rst_free", 8'(bus.free_count), 8'd2);
    tick();
    chk("sb_drained", 8'(exp_q.size()), 8'd0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
